// File: rtl/cache_pkg.sv
// Shared cache-side widths and the write-buffer entry layout.
package cache_pkg;

    localparam int NUM_WAYS   = 4;
    localparam int DATA_WIDTH = 32;

    typedef struct packed {
        logic [NUM_WAYS-1:0]   way;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO; caller guarantees no push when full, no pop when empty.
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              wr_entry,
    input  logic          pop,
    output T              rd_entry,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    // Storage carries no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= wr_entry;
    end

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_entry = mem[head];

endmodule

// File: rtl/write_buffer.sv
// Store write buffer: queues one-hot way stores and drains them to the cache
// write stage one per cycle through a single-cycle output register.
module write_buffer #(
    parameter int NUM_WAYS   = cache_pkg::NUM_WAYS,
    parameter int DATA_WIDTH = cache_pkg::DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [NUM_WAYS-1:0]          req_way,
    input  logic [DATA_WIDTH-1:0]        req_data,
    input  logic                         cache_busy,
    output logic [NUM_WAYS-1:0]          targetWay,
    output logic [DATA_WIDTH-1:0]        data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         way_err
);
    import cache_pkg::*;

    wb_entry_t in_entry;
    wb_entry_t head_entry;
    logic      way_ok;
    logic      accept;
    logic      push;
    logic      pop;

    assign req_ready = (count < DEPTH);
    assign accept    = req_valid && req_ready;
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign way_ok    = (req_way != '0) && ((req_way & (req_way - 1'b1)) == '0);
    assign push      = accept && way_ok;
    // Pop depends only on pre-edge occupancy, so a just-written entry is never popped.
    assign pop       = (count != '0) && !cache_busy;

    assign in_entry.way  = req_way;
    assign in_entry.data = req_data;

    sync_fifo #(
        .T     (wb_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wr_entry (in_entry),
        .pop      (pop),
        .rd_entry (head_entry),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            targetWay <= '0;
            data      <= '0;
            way_err   <= 1'b0;
        end else begin
            if (pop) begin
                targetWay <= head_entry.way;
                data      <= head_entry.data;
            end else begin
                targetWay <= '0;
                data      <= '0;
            end
            if (accept && !way_ok) way_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: a small occupancy model plus a queue of accepted stores.
module tb_write_buffer;
    import cache_pkg::*;

    localparam int DEPTH = 4;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        req_valid = 1'b0;
    logic                        req_ready;
    logic [NUM_WAYS-1:0]         req_way = '0;
    logic [DATA_WIDTH-1:0]       req_data = '0;
    logic                        cache_busy = 1'b0;
    logic [NUM_WAYS-1:0]         targetWay;
    logic [DATA_WIDTH-1:0]       data;
    logic [$clog2(DEPTH+1)-1:0]  count;
    logic                        way_err;

    int n_checks = 0;
    int n_errors = 0;

    wb_entry_t sb[$];
    int        m_cnt = 0;
    logic      m_vld = 1'b0;
    logic      m_err = 1'b0;
    logic      mon_en = 1'b0;

    write_buffer #(.NUM_WAYS(NUM_WAYS), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_way    (req_way),
        .req_data   (req_data),
        .cache_busy (cache_busy),
        .targetWay  (targetWay),
        .data       (data),
        .count      (count),
        .way_err    (way_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic onehot(input logic [NUM_WAYS-1:0] w);
        return $countones(w) == 1;
    endfunction

    // Reference model: accepted stores go to the scoreboard at the edge they are taken.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_cnt = 0;
            m_vld = 1'b0;
            m_err = 1'b0;
            sb.delete();
        end else begin
            automatic logic ready = (m_cnt < DEPTH);
            automatic logic pop   = (m_cnt > 0) && !cache_busy;
            automatic logic push  = req_valid && ready && onehot(req_way);
            m_vld = pop;
            if (req_valid && ready && !onehot(req_way)) m_err = 1'b1;
            if (push) sb.push_back('{way: req_way, data: req_data});
            m_cnt = m_cnt + int'(push) - int'(pop);
        end
    end

    // Monitor: outputs are sampled on the falling edge, away from state updates.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            check("ready", req_ready, m_cnt < DEPTH);
            check("count", count, m_cnt);
            check("way_err", way_err, m_err);
            check("write_valid", targetWay != '0, m_vld);
            if (targetWay != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", targetWay, 0);
                end else begin
                    automatic wb_entry_t e = sb.pop_front();
                    check("way", targetWay, e.way);
                    check("data", data, e.data);
                end
            end else begin
                check("data_idle", data, 0);
            end
        end
    end

    task automatic drive(input logic v, input logic [NUM_WAYS-1:0] w,
                         input logic [DATA_WIDTH-1:0] d, input logic busy);
        @(negedge clk);
        req_valid  = v;
        req_way    = w;
        req_data   = d;
        cache_busy = busy;
    endtask

    task automatic idle(input int n, input logic busy);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, busy);
    endtask

    initial begin
        // Reset state
        idle(2, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        check("rst_ready", req_ready, 1);
        check("rst_count", count, 0);
        check("rst_way", targetWay, 0);

        // Single store: write visible during the cycle two edges after the push
        drive(1'b1, 4'b0010, 32'hDEADBEEF, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        check("single_pend", targetWay, 0);
        drive(1'b0, '0, '0, 1'b0);
        check("single_way", targetWay, 4'b0010);
        check("single_data", data, 32'hDEADBEEF);
        drive(1'b0, '0, '0, 1'b0);
        check("single_done", targetWay, 0);
        check("single_cnt", count, 0);

        // Fill while busy, fifth push refused, then drain in order
        for (int i = 0; i < 5; i++) drive(1'b1, 4'b0001 << (i % 4), 32'hA000_0000 + i, 1'b1);
        drive(1'b0, '0, '0, 1'b1);
        check("full_ready", req_ready, 0);
        check("full_count", count, 4);
        idle(7, 1'b0);
        check("drain_cnt", count, 0);

        // Pointer wrap: interleaved pushes with draining enabled
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'b0001 << ($urandom_range(0, 3)), $urandom, 1'b0);
            if (i % 3 == 2) idle(1, 1'b0);
        end
        idle(4, 1'b0);
        check("wrap_empty", sb.size(), 0);

        // Simultaneous push and pop at count 2
        drive(1'b1, 4'b0100, 32'h1111_0001, 1'b1);
        drive(1'b1, 4'b0100, 32'h1111_0002, 1'b1);
        drive(1'b1, 4'b1000, 32'h1111_0003, 1'b0);
        drive(1'b0, '0, '0, 1'b1);
        check("pushpop_cnt", count, 2);
        idle(4, 1'b0);

        // Bad way: handshake completes, nothing stored, flag sticks
        drive(1'b1, 4'b0110, 32'hBAD0_BAD0, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        check("bad_err", way_err, 1);
        check("bad_cnt", count, 0);
        idle(3, 1'b0);
        check("bad_sticky", way_err, 1);

        // Reset while a drain is in progress
        for (int i = 0; i < 3; i++) drive(1'b1, 4'b0001, 32'hC000_0000 + i, 1'b1);
        drive(1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        check("mid_write", targetWay, 4'b0001);
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        rst = 1'b0;
        check("mid_rst_way", targetWay, 0);
        check("mid_rst_cnt", count, 0);
        check("mid_rst_err", way_err, 0);
        idle(4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 The block SHALL have parameter NUM_WAYS, default 4, number of cache ways (one-hot way-select width).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, store data width.
REQ-003 The block SHALL have parameter DEPTH, default 4, buffer entries; power of two, at least 2.
REQ-004 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, 1, CPU store request present.
REQ-007 The block SHALL have port req_ready, output, 1, buffer can accept a store.
REQ-008 The block SHALL have port req_way, input, NUM_WAYS, one-hot hit way for the store.
REQ-009 The block SHALL have port req_data, input, DATA_WIDTH, store data.
REQ-010 The block SHALL have port cache_busy, input, 1, cache array is occupied; blocks draining.
REQ-011 The block SHALL have port targetWay, output, NUM_WAYS, one-hot way for the downstream write stage; all-zero means no write.
REQ-012 The block SHALL have port data, output, DATA_WIDTH, write data for the downstream write stage.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH+1), number of occupied entries.
REQ-014 The block SHALL have port way_err, output, 1, sticky flag for a non-one-hot req_way.

Function
REQ-015 The block SHALL drive req_ready = (count < DEPTH), combinationally from registered state only; there is no bypass when full.
REQ-016 The block SHALL treat a push as occurring at a rising edge where req_valid && req_ready.
REQ-017 On a push with a one-hot req_way, the block SHALL write {req_way, req_data} at the tail and advance the tail modulo DEPTH.
REQ-018 On a push with a zero or multi-hot req_way, the block SHALL complete the handshake, discard the entry, and set way_err.
REQ-019 The block SHALL treat a pop as occurring at a rising edge where count > 0 && !cache_busy.
REQ-020 On a pop, the block SHALL load the head entry into the output register and advance the head modulo DEPTH.
REQ-021 The block SHALL hold targetWay and data for exactly one cycle after a pop, then return both to zero.
REQ-022 In any cycle that does not follow a pop, the block SHALL drive targetWay = 0 and data = 0.
REQ-023 The block SHALL issue at most one write per cycle; back-to-back pops SHALL produce consecutive one-cycle writes.
REQ-024 The block SHALL have a minimum latency of 2 cycles: a push at edge E gives a pop at E+1 and targetWay valid during cycle E+1..E+2.
REQ-025 The block SHALL NOT bypass on an empty push; an entry is never popped at the edge that writes it.
REQ-026 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-027 The block SHALL drain entries strictly in FIFO order; same-way entries SHALL NOT be merged or reordered.
REQ-028 While cache_busy is high, the block SHALL hold the head entry and continue to accept pushes until full.

Reset
REQ-029 When rst is high at a rising edge, the block SHALL clear the head and tail pointers, count, way_err, targetWay and data to 0; req_ready SHALL be 1 after that edge.
REQ-030 On a reset mid-operation, the block SHALL discard all buffered entries, and the write in flight SHALL NOT appear after the reset edge.
REQ-031 Reset SHALL take priority over any simultaneous push or pop.

Structure
REQ-032 NUM_WAYS, DATA_WIDTH and a packed write-entry struct typedef {way, data} SHALL live in shared package cache_pkg.
REQ-033 Entry storage and pointers SHALL be a single sub-module, sync_fifo, parameterised by entry type and DEPTH.
REQ-034 Push-validity checking and the output register SHALL reside in write_buffer.

Verification
REQ-035 The bench SHALL cover a single store: push way=4'b0010, data=32'hDEADBEEF with busy=0 -> targetWay=4'b0010, data=32'hDEADBEEF for one cycle, 2 cycles after the push edge; count returns to 0.
REQ-036 The bench SHALL cover fill then drain: busy=1, 5 pushes -> req_ready low after 4, count=4; drop busy -> 4 consecutive one-cycle writes in push order.
REQ-037 The bench SHALL cover pointer wrap: 10 pushes/pops interleaved with DEPTH=4 -> output sequence matches input sequence exactly.
REQ-038 The bench SHALL cover a bad way: push way=4'b0110 -> no write issued, count unchanged, way_err=1 until rst.
REQ-039 The bench SHALL cover reset mid-drain: 3 entries buffered, pop in progress, rst for 1 cycle -> targetWay=0 the following cycle, count=0, no further writes.
REQ-040 The bench SHALL cover simultaneous push and pop at count=2 -> count stays 2 and ordering is preserved.
